// File: rtl/power_peak_detect_pkg.sv
// power_peak_detect_pkg
//   Shared definitions for the spectrum peak detector and its upstream
//   complex-power accumulator stage.
//   - state_t        : frame-tracking FSM states
//   - PPD_WIDTH      : default accumulated-power word width
//   - PPD_ORDER_LOG2 : default log2 of FFT bins per spectrum frame
package power_peak_detect_pkg;

    typedef enum logic {
        IDLE  = 1'b0,   // no frame in progress
        ACCUM = 1'b1    // frame in progress
    } state_t;

    localparam int PPD_WIDTH      = 82;
    localparam int PPD_ORDER_LOG2 = 12;

endpackage

// File: rtl/power_peak_detect_max_tracker.sv
// max_tracker
//   Compare-and-hold of the running maximum and the index where it occurred.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     load            : start a new set; value becomes the maximum at index 0
//     update          : offer value/idx; taken only if strictly greater
//     value, idx      : candidate sample and its index
//     max_val,max_idx : registered maximum and its index
//     nxt_val,nxt_idx : maximum including the current candidate, so the
//                       parent can capture a final result on the same edge
module max_tracker
    import power_peak_detect_pkg::*;
#(
    parameter int WIDTH = PPD_WIDTH,
    parameter int IDX_W = PPD_ORDER_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             update,
    input  logic [WIDTH-1:0] value,
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] max_val,
    output logic [IDX_W-1:0] max_idx,
    output logic [WIDTH-1:0] nxt_val,
    output logic [IDX_W-1:0] nxt_idx
);

    // Strict compare: on ties the earlier (lower) index is kept.
    always_comb begin
        nxt_val = max_val;
        nxt_idx = max_idx;
        if (load) begin
            nxt_val = value;
            nxt_idx = '0;
        end else if (update && (value > max_val)) begin
            nxt_val = value;
            nxt_idx = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (load || update) begin
            max_val <= nxt_val;
            max_idx <= nxt_idx;
        end
    end

endmodule

// File: rtl/power_peak_detect.sv
// power_peak_detect
//   Per-spectrum peak finder downstream of the complex-power accumulator.
//   Tracks the maximum power and its bin over each frame of 2^ORDER_LOG2
//   bins and publishes peak, bin and threshold flag once per full frame.
//   A frame_start arriving mid-frame aborts the partial frame (frame_short)
//   and restarts tracking from that sample.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     clken        : one input bin accepted on this cycle
//     frame_start  : with clken, marks bin 0 of a frame
//     power        : unsigned accumulated bin power
//     threshold    : unsigned, sampled on the last-bin cycle
//     peak_valid   : one-cycle pulse, new result on peak_*
//     peak_power   : maximum power of the last completed frame
//     peak_bin     : bin index of that maximum
//     peak_over    : peak_power > threshold
//     frame_short  : one-cycle pulse, frame aborted by early frame_start
module power_peak_detect
    import power_peak_detect_pkg::*;
#(
    parameter int ORDER_LOG2 = PPD_ORDER_LOG2,
    parameter int WIDTH      = PPD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clken,
    input  logic                  frame_start,
    input  logic [WIDTH-1:0]      power,
    input  logic [WIDTH-1:0]      threshold,
    output logic                  peak_valid,
    output logic [WIDTH-1:0]      peak_power,
    output logic [ORDER_LOG2-1:0] peak_bin,
    output logic                  peak_over,
    output logic                  frame_short
);

    // bin_cnt is exactly ORDER_LOG2 bits, so all-ones is bin N-1.
    localparam logic [ORDER_LOG2-1:0] LAST_BIN = {ORDER_LOG2{1'b1}};
    localparam logic [ORDER_LOG2-1:0] ONE_BIN  = {{(ORDER_LOG2-1){1'b0}}, 1'b1};

    state_t                  state, state_nxt;
    logic [ORDER_LOG2-1:0]   bin_cnt, cnt_nxt;
    logic                    trk_load, trk_update;
    logic                    fire, short_det;
    logic [WIDTH-1:0]        trk_max_val, trk_nxt_val;
    logic [ORDER_LOG2-1:0]   trk_max_idx, trk_nxt_idx;

    max_tracker #(
        .WIDTH (WIDTH),
        .IDX_W (ORDER_LOG2)
    ) u_max_tracker (
        .clk     (clk),
        .rst     (rst),
        .load    (trk_load),
        .update  (trk_update),
        .value   (power),
        .idx     (bin_cnt),
        .max_val (trk_max_val),
        .max_idx (trk_max_idx),
        .nxt_val (trk_nxt_val),
        .nxt_idx (trk_nxt_idx)
    );

    // Next-state and control decode; clken=0 leaves everything unchanged.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = bin_cnt;
        trk_load   = 1'b0;
        trk_update = 1'b0;
        fire       = 1'b0;
        short_det  = 1'b0;
        if (clken) begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        trk_load  = 1'b1;
                        cnt_nxt   = ONE_BIN;
                        state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    if (frame_start) begin
                        // Early restart: drop the partial frame, this sample is bin 0.
                        trk_load  = 1'b1;
                        short_det = 1'b1;
                        cnt_nxt   = ONE_BIN;
                    end else begin
                        trk_update = 1'b1;
                        if (bin_cnt == LAST_BIN) begin
                            fire      = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = bin_cnt + ONE_BIN;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output stage: the final max is taken from the tracker's next value so
    // the last bin is included without an extra cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bin_cnt     <= '0;
            peak_valid  <= 1'b0;
            frame_short <= 1'b0;
            peak_power  <= '0;
            peak_bin    <= '0;
            peak_over   <= 1'b0;
        end else begin
            state       <= state_nxt;
            bin_cnt     <= cnt_nxt;
            peak_valid  <= fire;
            frame_short <= short_det;
            if (fire) begin
                peak_power <= trk_nxt_val;
                peak_bin   <= trk_nxt_idx;
                peak_over  <= (trk_nxt_val > threshold);
            end
        end
    end

endmodule

// File: tb/tb_power_peak_detect.sv
module tb_power_peak_detect;

    localparam int OL2 = 3;
    localparam int W   = 82;

    typedef logic [W-1:0] frame_t [8];

    typedef struct {
        int             kind;   // 1 = peak result, 2 = frame_short
        logic [W-1:0]   pw;
        logic [OL2-1:0] bin;
        logic           over;
        int             due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clken = 1'b0;
    logic           frame_start = 1'b0;
    logic [W-1:0]   power = '0;
    logic [W-1:0]   threshold = '0;
    logic           peak_valid;
    logic [W-1:0]   peak_power;
    logic [OL2-1:0] peak_bin;
    logic           peak_over;
    logic           frame_short;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];
    int   vcycles[$];

    logic [W-1:0]   hold_pw = '0;
    logic [OL2-1:0] hold_bin = '0;
    logic           hold_over = 1'b0;

    power_peak_detect #(.ORDER_LOG2(OL2), .WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .clken       (clken),
        .frame_start (frame_start),
        .power       (power),
        .threshold   (threshold),
        .peak_valid  (peak_valid),
        .peak_power  (peak_power),
        .peak_bin    (peak_bin),
        .peak_over   (peak_over),
        .frame_short (frame_short)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (peak_valid || frame_short) begin
                chk("pulse_overlap", 82'(peak_valid & frame_short), 82'd0);
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse: valid=%0b short=%0b expected none (cycle %0d)",
                             peak_valid, frame_short, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_cycle", 82'(cyc), 82'(e.due));
                    if (peak_valid) begin
                        chk("pulse_kind_peak", 82'(e.kind), 82'd1);
                        chk("peak_power", peak_power, e.pw);
                        chk("peak_bin", 82'(peak_bin), 82'(e.bin));
                        chk("peak_over", 82'(peak_over), 82'(e.over));
                        hold_pw   = e.pw;
                        hold_bin  = e.bin;
                        hold_over = e.over;
                        vcycles.push_back(cyc);
                    end else begin
                        chk("pulse_kind_short", 82'(e.kind), 82'd2);
                    end
                end
            end
            if (!peak_valid) begin
                chk("hold_power", peak_power, hold_pw);
                chk("hold_bin_over", 82'({peak_bin, peak_over}), 82'({hold_bin, hold_over}));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            clken       = 1'b0;
            frame_start = 1'($urandom);
            power       = 82'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic send_bin(input logic fs, input logic [W-1:0] p, input logic [W-1:0] thr,
                            input int gap, input int kind, input logic [W-1:0] ep,
                            input logic [OL2-1:0] eb, input logic eo);
        exp_t e;
        idle(gap);
        clken       = 1'b1;
        frame_start = fs;
        power       = p;
        threshold   = thr;
        if (kind != 0) begin
            e.kind = kind; e.pw = ep; e.bin = eb; e.over = eo; e.due = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        clken       = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input frame_t v, input logic [W-1:0] thr, input bit gaps,
                              input int first_kind, input logic [W-1:0] ep,
                              input logic [OL2-1:0] eb, input logic eo);
        for (int i = 0; i < 8; i++) begin
            send_bin(i == 0, v[i], thr, gaps ? int'($urandom_range(0, 2)) : 0,
                     (i == 7) ? 1 : ((i == 0) ? first_kind : 0),
                     ep, eb, eo);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 82'(peak_valid), 82'd0);
        chk({tag, "_short"}, 82'(frame_short), 82'd0);
        chk({tag, "_power"}, peak_power, 82'd0);
        chk({tag, "_bin"}, 82'(peak_bin), 82'd0);
        chk({tag, "_over"}, 82'(peak_over), 82'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        frame_t fa, fz, fbig, fr, fm, f1, f2;
        logic [W-1:0] big;
        big  = 82'd1 << 81;
        fa   = '{82'd5, 82'd9, 82'd3, 82'd9, 82'd1, 82'd0, 82'd2, 82'd7};
        fz   = '{default: 82'd0};
        fbig = '{82'd1, 82'd1, 82'd1, 82'd1, 82'd1, 82'd1, 82'd1, big};
        fr   = '{82'd3, 82'd4, 82'd8, 82'd8, 82'd2, 82'd1, 82'd0, 82'd5};
        fm   = '{default: 82'd2};
        f1   = '{82'd0, 82'd1, 82'd2, 82'd3, 82'd4, 82'd5, 82'd6, 82'd7};
        f2   = '{82'd7, 82'd6, 82'd5, 82'd4, 82'd3, 82'd2, 82'd1, 82'd0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Samples before any frame_start are dropped
        for (int i = 0; i < 6; i++) send_bin(1'b0, 82'(1000 + i), 82'd0, int'($urandom_range(0, 2)), 0, '0, '0, 1'b0);
        idle(2);

        // Main frames, with random clken gaps
        send_frame(fa, 82'd8, 1'b1, 0, 82'd9, 3'd1, 1'b1);
        send_frame(fa, 82'd9, 1'b1, 0, 82'd9, 3'd1, 1'b0);
        send_frame(fz, 82'd0, 1'b1, 0, 82'd0, 3'd0, 1'b0);
        send_frame(fbig, 82'd0, 1'b0, 0, big, 3'd7, 1'b1);
        send_frame(fbig, big, 1'b0, 0, big, 3'd7, 1'b0);
        idle(2);

        // Early frame_start at bin 4, then a full restarted frame
        send_bin(1'b1, 82'd10, 82'd0, 0, 0, '0, '0, 1'b0);
        send_bin(1'b0, 82'd20, 82'd0, 1, 0, '0, '0, 1'b0);
        send_bin(1'b0, 82'd30, 82'd0, 0, 0, '0, '0, 1'b0);
        send_bin(1'b0, 82'd40, 82'd0, 0, 0, '0, '0, 1'b0);
        send_frame(fr, 82'd7, 1'b1, 2, 82'd8, 3'd2, 1'b1);
        idle(2);

        // Reset asserted mid-frame
        send_bin(1'b1, 82'd50, 82'd0, 0, 0, '0, '0, 1'b0);
        send_bin(1'b0, 82'd60, 82'd0, 0, 0, '0, '0, 1'b0);
        send_bin(1'b0, 82'd70, 82'd0, 0, 0, '0, '0, 1'b0);
        rst = 1'b1;
        hold_pw = '0; hold_bin = '0; hold_over = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) send_bin(1'b0, 82'(900 + i), 82'd0, int'($urandom_range(0, 1)), 0, '0, '0, 1'b0);
        send_frame(fm, 82'd1, 1'b1, 0, 82'd2, 3'd0, 1'b1);
        idle(2);

        // Back-to-back frames, clken high every cycle
        vcycles.delete();
        send_frame(f1, 82'd6, 1'b0, 0, 82'd7, 3'd7, 1'b1);
        send_frame(f2, 82'd7, 1'b0, 0, 82'd7, 3'd0, 1'b0);
        idle(3);
        chk("b2b_pulse_count", 82'(vcycles.size()), 82'd2);
        if (vcycles.size() == 2) chk("b2b_spacing", 82'(vcycles[1] - vcycles[0]), 82'd8);

        idle(3);
        chk("scoreboard_empty", 82'(sb.size()), 82'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
